// File: rtl/alu_pkg.sv
// Shared opcode codes, legality check and issue-FSM state type for the alu issue stage.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_NOT = 3'b011;
    localparam logic [OP_W-1:0] OP_CLR = 3'b100;
    localparam logic [OP_W-1:0] OP_OR  = 3'b101;
    localparam logic [OP_W-1:0] OP_AND = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Codes 000 and 111 have no alu function.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op != 3'b000) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit alu driven by the issue stage; unused codes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   ALU_Sel,
    output logic [DATA_W-1:0] ALU_Out
);

    always_comb begin
        ALU_Out = '0;
        case (ALU_Sel)
            OP_ADD:  ALU_Out = A + B;
            OP_SUB:  ALU_Out = A - B;
            OP_NOT:  ALU_Out = ~A;
            OP_CLR:  ALU_Out = '0;
            OP_OR:   ALU_Out = A | B;
            OP_AND:  ALU_Out = A & B;
            default: ALU_Out = '0;
        endcase
    end

endmodule

// File: rtl/alu_regfile.sv
// Operand register file: two asynchronous read ports, one synchronous write port.
module alu_regfile #(
    parameter  int unsigned DATA_W   = 16,
    parameter  int unsigned NUM_REGS = 4,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a_c,
    output logic [DATA_W-1:0] rdata_b_c
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a_c = regs[raddr_a];
    assign rdata_b_c = regs[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage: accepts one instruction, drives the alu from the register file,
// captures and writes back the result, and hands it downstream with valid/ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter  int unsigned DATA_W   = 16,
    parameter  int unsigned NUM_REGS = 4,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_rd,
    output logic              res_err
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rd_a_c;
    logic [DATA_W-1:0] rd_b_c;
    logic [ADDR_W-1:0] rd_q;
    logic              illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instr_valid) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // External loads only land in IDLE; EXEC owns the write port for writeback.
    always_comb begin
        instr_ready = 1'b0;
        accept      = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = wr_addr;
        rf_wdata    = wr_data;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid;
                rf_we       = wr_en;
            end
            EXEC: begin
                rf_we    = !illegal_q;
                rf_waddr = rd_q;
                rf_wdata = alu_out;
            end
            default: ;
        endcase
    end

    alu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .raddr_a   (instr_rs1),
        .raddr_b   (instr_rs2),
        .rdata_a_c (rd_a_c),
        .rdata_b_c (rd_b_c)
    );

    // Operand launch: alu inputs change only on an accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= OP_CLR;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            alu_a     <= rd_a_c;
            alu_b     <= rd_b_c;
            alu_sel   <= instr_op;
            rd_q      <= instr_rd;
            illegal_q <= !is_legal_op(instr_op);
        end
    end

    // Result capture in EXEC, held through DONE until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            res_err   <= 1'b0;
        end else if (state == EXEC) begin
            res_valid <= 1'b1;
            res_data  <= illegal_q ? '0 : alu_out;
            res_rd    <= rd_q;
            res_err   <= illegal_q;
        end else if ((state == DONE) && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl wired to the alu: transaction-level model plus literal pins.
module tb_alu_issue_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [2:0]    instr_op = 3'b000;
    logic [AW-1:0] instr_rs1 = '0;
    logic [AW-1:0] instr_rs2 = '0;
    logic [AW-1:0] instr_rd = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [DW-1:0] alu_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_rd;
    logic          res_err;

    alu_issue_ctrl #(.DATA_W(DW), .NUM_REGS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_rd    (instr_rd),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_err     (res_err)
    );

    alu #(.DATA_W(DW)) u_alu (
        .A       (alu_a),
        .B       (alu_b),
        .ALU_Sel (alu_sel),
        .ALU_Out (alu_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural model state and expected visible outputs
    logic [DW-1:0] rf_m [4];
    logic          exp_ready, exp_valid, exp_err;
    logic [DW-1:0] exp_data, exp_a, exp_b;
    logic [AW-1:0] exp_rd;
    logic [2:0]    exp_sel;
    bit            chk_en = 1'b0;
    logic [DW-1:0] got_data;
    logic          got_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (op)
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return ~a;
            3'b101:  return a | b;
            3'b110:  return a & b;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) rf_m[i] = '0;
        exp_ready = 1'b1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_data  = '0;
        exp_rd    = '0;
        exp_a     = '0;
        exp_b     = '0;
        exp_sel   = 3'b100;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_ready", 32'(instr_ready), 32'(exp_ready));
            check("res_valid",   32'(res_valid),   32'(exp_valid));
            check("res_data",    32'(res_data),    32'(exp_data));
            check("res_rd",      32'(res_rd),      32'(exp_rd));
            check("res_err",     32'(res_err),     32'(exp_err));
            check("alu_a",       32'(alu_a),       32'(exp_a));
            check("alu_b",       32'(alu_b),       32'(exp_b));
            check("alu_sel",     32'(alu_sel),     32'(exp_sel));
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rf_m[a] = d;
    endtask

    // One full instruction: accept, exec, optional stall in DONE (with ignored loads), retire.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input bit same_wr, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input int stall);
        logic [DW-1:0] ea, eb, r;
        logic          legal;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
        wr_en = same_wr; wr_addr = wa; wr_data = wd; res_ready = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0; wr_en = 1'b0;
        ea = rf_m[rs1];
        eb = rf_m[rs2];
        if (same_wr) rf_m[wa] = wd;
        legal = (op != 3'b000) && (op != 3'b111);
        r = legal ? model_alu(op, ea, eb) : '0;
        exp_a = ea; exp_b = eb; exp_sel = op; exp_ready = 1'b0;
        @(posedge clk); #1;
        if (legal) rf_m[rd] = r;
        exp_valid = 1'b1; exp_data = r; exp_rd = rd; exp_err = !legal;
        got_data = res_data;
        got_err  = res_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'hDEAD;
        end
        @(negedge clk);
        wr_en = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_valid = 1'b0; exp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_alu_sel", 32'(alu_sel), 32'h4);
        check("rst_instr_ready", 32'(instr_ready), 32'h1);
        rst_n = 1'b1;

        load(2'd1, 16'h0003);
        load(2'd2, 16'h0005);

        issue(3'b001, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 16'h0, 0);
        check("add_lit", 32'(got_data), 32'h0008);
        check("add_err_lit", 32'(got_err), 32'h0);
        issue(3'b101, 2'd3, 2'd3, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("r3_after_add", 32'(got_data), 32'h0008);

        issue(3'b010, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("sub_lit", 32'(got_data), 32'hFFFE);
        issue(3'b011, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("not_lit", 32'(got_data), 32'hFFFC);
        issue(3'b101, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("or_lit", 32'(got_data), 32'h0007);
        issue(3'b110, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("and_lit", 32'(got_data), 32'h0001);
        issue(3'b100, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("clr_lit", 32'(got_data), 32'h0000);

        issue(3'b000, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 16'h0, 0);
        check("ill000_err", 32'(got_err), 32'h1);
        check("ill000_data", 32'(got_data), 32'h0000);
        issue(3'b101, 2'd3, 2'd3, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("r3_after_ill000", 32'(got_data), 32'h0008);
        issue(3'b111, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 16'h0, 0);
        check("ill111_err", 32'(got_err), 32'h1);
        issue(3'b101, 2'd3, 2'd3, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("r3_after_ill111", 32'(got_data), 32'h0008);

        issue(3'b001, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 16'h0, 5);
        check("stall_add", 32'(got_data), 32'h0008);
        issue(3'b101, 2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("r1_after_stall_wr", 32'(got_data), 32'h0003);

        issue(3'b001, 2'd1, 2'd2, 2'd0, 1'b1, 2'd1, 16'h00FF, 0);
        check("same_edge_add", 32'(got_data), 32'h0008);
        issue(3'b101, 2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("r1_after_same_edge", 32'(got_data), 32'h00FF);

        // Reset while the instruction sits in EXEC
        @(negedge clk);
        chk_en = 1'b0;
        instr_valid = 1'b1; instr_op = 3'b001; instr_rs1 = 2'd1; instr_rs2 = 2'd2; instr_rd = 2'd3;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("pre_rst_alu_a", 32'(alu_a), 32'h00FF);
        #2 rst_n = 1'b0;
        #1;
        check("rst_exec_valid", 32'(res_valid), 32'h0);
        check("rst_exec_ready", 32'(instr_ready), 32'h1);
        check("rst_exec_alu_a", 32'(alu_a), 32'h0000);
        @(posedge clk); #1;
        check("rst_hold_valid", 32'(res_valid), 32'h0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        chk_en = 1'b1;
        issue(3'b101, 2'd3, 2'd3, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("r3_after_rst", 32'(got_data), 32'h0000);
        issue(3'b101, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 16'h0, 0);
        check("r1r2_after_rst", 32'(got_data), 32'h0000);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
